// File: rtl/wall_probe_scheduler_if.sv
// Wall lookup bus between the probe scheduler (master) and the single
// shared Is_Wall lookup (slave).
interface wall_probe_scheduler_if;
  logic       Wall_Req;
  logic [9:0] Wall_X;
  logic [9:0] Wall_Y;
  logic       Is_Wall;

  modport master (output Wall_Req, output Wall_X, output Wall_Y, input Is_Wall);
  modport slave  (input Wall_Req, input Wall_X, input Wall_Y, output Is_Wall);
endinterface

// File: rtl/wall_probe_scheduler.sv
// Shares one wall lookup port among all movers. Each frame the mover centres
// are snapshotted, four probes per mover (left, up, right, down) are issued
// back to back, results are collected through a tag pipeline into a shadow
// vector and published to No_Move_o in one step together with Valid_o.
//
// Optional build macro: TUNNEL_WRAP_EN folds horizontal probe X coordinates
// into the playfield tunnel (X<120 -> X+400, X>520 -> X-400).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for Frame_Tick_i; snapshot taken on the tick
// S_ISSUE | one probe per cycle, mover 0..N-1, dir left/up/right/down
// S_DRAIN | no requests; wait LOOKUP_LAT cycles for outstanding results
// S_COMMIT| No_Move_o/Valid_o presented for one cycle, back to idle
module wall_probe_scheduler #(
  parameter int NUM_MOVERS = 5,
  parameter int PROBE_OFS  = 8,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Frame_Tick_i,
  input  logic [10*NUM_MOVERS-1:0] Pos_X_i,
  input  logic [10*NUM_MOVERS-1:0] Pos_Y_i,
  wall_probe_scheduler_if.master  wall,
  output logic [4*NUM_MOVERS-1:0] No_Move_o,
  output logic                    Valid_o,
  output logic                    Busy_o,
  output logic                    Overrun_o
);

  localparam int MW = (NUM_MOVERS > 1) ? $clog2(NUM_MOVERS) : 1;
  localparam int CW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam logic [9:0]    OFS      = 10'(PROBE_OFS);
  localparam logic [MW-1:0] LAST_MOV = MW'(NUM_MOVERS - 1);
  localparam logic [CW-1:0] DRAIN_LD = CW'(LOOKUP_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT} state_t;

  typedef struct packed {
    logic          vld;
    logic [MW-1:0] mover;
    logic [1:0]    dir;
  } tag_t;

  state_t                   state_q, state_d;
  logic [10*NUM_MOVERS-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [MW-1:0]            idx_q, idx_d;
  logic [1:0]               dir_q, dir_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  tag_t                     tag_q [LOOKUP_LAT];
  tag_t                     tag_d [LOOKUP_LAT];
  logic [4*NUM_MOVERS-1:0]  shadow_q, shadow_d;
  logic [4*NUM_MOVERS-1:0]  no_move_q, no_move_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;

  logic [9:0] cur_x, cur_y, probe_x, probe_y;
  logic [MW+1:0] cap_idx;

  // No_Move nibble is {up,down,left,right}; map probe direction to its bit.
  function automatic logic [1:0] dir_bit(input logic [1:0] d);
    case (d)
      2'd0:    dir_bit = 2'd1;
      2'd1:    dir_bit = 2'd3;
      2'd2:    dir_bit = 2'd0;
      default: dir_bit = 2'd2;
    endcase
  endfunction

  // Probe coordinate for the current mover/direction, modulo 1024.
  always_comb begin
    cur_x   = snap_x_q[10*int'(idx_q) +: 10];
    cur_y   = snap_y_q[10*int'(idx_q) +: 10];
    probe_x = cur_x;
    probe_y = cur_y;
    case (dir_q)
      2'd0:    probe_x = cur_x - OFS;
      2'd1:    probe_y = cur_y - OFS;
      2'd2:    probe_x = cur_x + OFS;
      default: probe_y = cur_y + OFS;
    endcase
`ifdef TUNNEL_WRAP_EN
    if (!dir_q[0]) begin
      if (probe_x < 10'd120)      probe_x = probe_x + 10'd400;
      else if (probe_x > 10'd520) probe_x = probe_x - 10'd400;
    end
`endif
  end

  assign wall.Wall_Req = (state_q == S_ISSUE);
  assign wall.Wall_X   = (state_q == S_ISSUE) ? probe_x : 10'd0;
  assign wall.Wall_Y   = (state_q == S_ISSUE) ? probe_y : 10'd0;

  assign No_Move_o = no_move_q;
  assign Valid_o   = valid_q;
  assign Busy_o    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign Overrun_o = overrun_q;

  // Next-state logic: sweep sequencing, tag pipeline and result capture.
  always_comb begin
    state_d   = state_q;
    snap_x_d  = snap_x_q;
    snap_y_d  = snap_y_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    no_move_d = no_move_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    cap_idx   = {tag_q[LOOKUP_LAT-1].mover, dir_bit(tag_q[LOOKUP_LAT-1].dir)};

    tag_d[0] = '0;
    for (int i = 1; i < LOOKUP_LAT; i++) tag_d[i] = tag_q[i-1];

    if (tag_q[LOOKUP_LAT-1].vld) shadow_d[cap_idx] = wall.Is_Wall;

    // A tick anywhere outside IDLE (COMMIT included) is dropped but flagged.
    if (Frame_Tick_i && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (Frame_Tick_i) begin
          snap_x_d = Pos_X_i;
          snap_y_d = Pos_Y_i;
          idx_d    = '0;
          dir_d    = 2'd0;
          shadow_d = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tag_d[0] = '{vld: 1'b1, mover: idx_q, dir: dir_q};
        dir_d    = dir_q + 2'd1;
        if (dir_q == 2'd3) begin
          if (idx_q == LAST_MOV) begin
            cnt_d   = DRAIN_LD;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + MW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          // shadow_d already holds the final result arriving this cycle.
          no_move_d = shadow_d;
          valid_d   = 1'b1;
          state_d   = S_COMMIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sweep in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      snap_x_q  <= '0;
      snap_y_q  <= '0;
      idx_q     <= '0;
      dir_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      no_move_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < LOOKUP_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      snap_x_q  <= snap_x_d;
      snap_y_q  <= snap_y_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      no_move_q <= no_move_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < LOOKUP_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_wall_probe_scheduler.sv
// Bench for wall_probe_scheduler: one instance with LOOKUP_LAT=1 and one with
// LOOKUP_LAT=3 share stimulus; expected probes and results are queued at each
// Frame_Tick and checked by a monitor on the falling clock edge.
module tb_wall_probe_scheduler;
  localparam int N = 5;

  typedef struct {int cyc; logic [9:0] x; logic [9:0] y;} probe_t;
  typedef struct {int cyc; logic [4*N-1:0] nm;} res_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  logic Frame_Tick = 1'b0;
  logic [10*N-1:0] Pos_X, Pos_Y;
  logic [9:0] px_a [N];
  logic [9:0] py_a [N];

  logic [4*N-1:0] nm [2];
  logic vld [2], busy [2], ovr [2];
  logic wreq [2];
  logic [9:0] wx [2], wy [2];

  logic       wall_en = 1'b0;
  logic [9:0] wall_px = '0, wall_py = '0;
  logic [2:0] lpipe [2] = '{3'b0, 3'b0};

  probe_t pq [2][$];
  res_t   rq [2][$];
  logic [4*N-1:0] held [2] = '{'0, '0};
  int cyc = 0;
  int errors = 0, checks = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always_comb begin
    Pos_X = '0;
    Pos_Y = '0;
    for (int m = 0; m < N; m++) begin
      Pos_X[10*m +: 10] = px_a[m];
      Pos_Y[10*m +: 10] = py_a[m];
    end
  end

  wall_probe_scheduler_if bus0 ();
  wall_probe_scheduler_if bus1 ();

  wall_probe_scheduler #(.NUM_MOVERS(N), .PROBE_OFS(8), .LOOKUP_LAT(1)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Frame_Tick_i(Frame_Tick),
    .Pos_X_i(Pos_X), .Pos_Y_i(Pos_Y), .wall(bus0),
    .No_Move_o(nm[0]), .Valid_o(vld[0]), .Busy_o(busy[0]), .Overrun_o(ovr[0]));

  wall_probe_scheduler #(.NUM_MOVERS(N), .PROBE_OFS(8), .LOOKUP_LAT(3)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Frame_Tick_i(Frame_Tick),
    .Pos_X_i(Pos_X), .Pos_Y_i(Pos_Y), .wall(bus1),
    .No_Move_o(nm[1]), .Valid_o(vld[1]), .Busy_o(busy[1]), .Overrun_o(ovr[1]));

  assign wreq[0] = bus0.Wall_Req;
  assign wx[0]   = bus0.Wall_X;
  assign wy[0]   = bus0.Wall_Y;
  assign wreq[1] = bus1.Wall_Req;
  assign wx[1]   = bus1.Wall_X;
  assign wy[1]   = bus1.Wall_Y;

  // Lookup model: a single wall pixel, answered LOOKUP_LAT cycles later.
  always @(posedge Clk)
    for (int k = 0; k < 2; k++)
      lpipe[k] <= {lpipe[k][1:0],
                   wreq[k] && wall_en && (wx[k] == wall_px) && (wy[k] == wall_py)};
  assign bus0.Is_Wall = lpipe[0][0];
  assign bus1.Is_Wall = lpipe[1][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] probe_fn(input logic [9:0] x, input logic [9:0] y,
                                           input int d);
    logic [9:0] px, py;
    px = x;
    py = y;
    case (d)
      0: px = x - 10'd8;
      1: py = y - 10'd8;
      2: px = x + 10'd8;
      default: py = y + 10'd8;
    endcase
`ifdef TUNNEL_WRAP_EN
    if (d == 0 || d == 2) begin
      if (px < 10'd120)      px = px + 10'd400;
      else if (px > 10'd520) px = px - 10'd400;
    end
`endif
    return {px, py};
  endfunction

  // Monitor: every requested probe and every Valid pulse is checked against
  // the queues; between pulses No_Move must hold the last published value.
  always @(negedge Clk) begin
    probe_t p;
    res_t   r;
    for (int k = 0; k < 2; k++) begin
      if (wreq[k]) begin
        if (pq[k].size() == 0) chk($sformatf("dut%0d_spurious_req", k), 32'(wreq[k]), 32'd0);
        else begin
          p = pq[k].pop_front();
          chk($sformatf("dut%0d_req_cycle", k), cyc, p.cyc);
          chk($sformatf("dut%0d_wall_x", k), 32'(wx[k]), 32'(p.x));
          chk($sformatf("dut%0d_wall_y", k), 32'(wy[k]), 32'(p.y));
        end
      end
      if (vld[k]) begin
        if (rq[k].size() == 0) chk($sformatf("dut%0d_spurious_valid", k), 32'(vld[k]), 32'd0);
        else begin
          r = rq[k].pop_front();
          chk($sformatf("dut%0d_valid_cycle", k), cyc, r.cyc);
          chk($sformatf("dut%0d_no_move", k), 32'(nm[k]), 32'(r.nm));
          held[k] = r.nm;
        end
      end else begin
        chk($sformatf("dut%0d_no_move_hold", k), 32'(nm[k]), 32'(held[k]));
      end
    end
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic flush();
    for (int k = 0; k < 2; k++) begin
      pq[k].delete();
      rq[k].delete();
    end
  endtask

  // Frame_Tick plus the expected sweep; mover 0 may use literal probe values.
  task automatic tick_sweep(input logic [4*N-1:0] exp_nm, input bit use_lit,
                            input logic [9:0] lx [4], input logic [9:0] ly [4],
                            output int t);
    logic [19:0] pr;
    step();
    Frame_Tick = 1'b1;
    t = cyc;
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < N; m++)
        for (int d = 0; d < 4; d++) begin
          pr = probe_fn(px_a[m], py_a[m], d);
          if (use_lit && m == 0) pq[k].push_back('{t + 1 + 4*m + d, lx[d], ly[d]});
          else                   pq[k].push_back('{t + 1 + 4*m + d, pr[19:10], pr[9:0]});
        end
      rq[k].push_back('{t + 22 + 2*k, exp_nm});
    end
    step();
    Frame_Tick = 1'b0;
  endtask

  task automatic tick_only();
    Frame_Tick = 1'b1;
    step();
    Frame_Tick = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((pq[0].size() + pq[1].size() + rq[0].size() + rq[1].size()) != 0 && n < 100) begin
      step();
      n++;
    end
    chk("sweep_timeout", pq[0].size() + pq[1].size() + rq[0].size() + rq[1].size(), 0);
    flush();
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [9:0] lx [4];
    logic [9:0] ly [4];
    px_a = '{10'd320, 10'd100, 10'd200, 10'd600, 10'd4};
    py_a = '{10'd274, 10'd50, 10'd100, 10'd400, 10'd1020};
    #2 Reset_n = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_no_move", 32'(nm[k]), 0);
      chk("rst_valid", 32'(vld[k]), 0);
      chk("rst_busy", 32'(busy[k]), 0);
      chk("rst_overrun", 32'(ovr[k]), 0);
      chk("rst_wall_req", 32'(wreq[k]), 0);
      chk("rst_wall_x", 32'(wx[k]), 0);
      chk("rst_wall_y", 32'(wy[k]), 0);
    end
    Reset_n = 1'b1;
    step();

    // Basic sweep, no walls; mover 0 probes hand-computed.
    lx = '{10'd312, 10'd320, 10'd328, 10'd320};
    ly = '{10'd274, 10'd266, 10'd274, 10'd282};
    tick_sweep(20'h00000, 1'b1, lx, ly, t);
    at_cycle(t + 5);
    chk("busy_mid_dut0", 32'(busy[0]), 1);
    chk("busy_mid_dut1", 32'(busy[1]), 1);
    wait_done();
    chk("busy_after", 32'(busy[0]), 0);

    // Single wall right of mover 0; position change mid-sweep is ignored.
    wall_en = 1'b1; wall_px = 10'd328; wall_py = 10'd274;
    tick_sweep(20'h00001, 1'b0, lx, ly, t);
    at_cycle(t + 5);
    px_a[0] = 10'd10; py_a[0] = 10'd10;
    at_cycle(t + 15);
    px_a[0] = 10'd320; py_a[0] = 10'd274;
    wait_done();

    // Tick while busy: ignored, Overrun sticky across a following sweep.
    wall_en = 1'b0;
    tick_sweep(20'h00000, 1'b0, lx, ly, t);
    at_cycle(t + 10);
    tick_only();
    chk("overrun_dut0", 32'(ovr[0]), 1);
    chk("overrun_dut1", 32'(ovr[1]), 1);
    wait_done();
    wall_en = 1'b1;
    tick_sweep(20'h00001, 1'b0, lx, ly, t);
    wait_done();
    chk("overrun_sticky_dut0", 32'(ovr[0]), 1);
    chk("overrun_sticky_dut1", 32'(ovr[1]), 1);

    // Reset mid-sweep: abort, outputs cleared, no Valid.
    wall_en = 1'b0;
    tick_sweep(20'h00000, 1'b0, lx, ly, t);
    at_cycle(t + 12);
    Reset_n = 1'b0;
    flush();
    held = '{'0, '0};
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort_busy", 32'(busy[k]), 0);
      chk("abort_no_move", 32'(nm[k]), 0);
      chk("abort_overrun", 32'(ovr[k]), 0);
      chk("abort_wall_req", 32'(wreq[k]), 0);
    end
    at_cycle(t + 14);
    Reset_n = 1'b1;
    at_cycle(t + 30);
    wall_en = 1'b1;
    tick_sweep(20'h00001, 1'b0, lx, ly, t);
    wait_done();

    // Mover 2 walled below only.
    wall_px = 10'd200; wall_py = 10'd108;
    tick_sweep(20'h00400, 1'b0, lx, ly, t);
    wait_done();

    // Tunnel mouth: left probe of (124,230), wall placed where it should land.
    px_a[0] = 10'd124; py_a[0] = 10'd230;
`ifdef TUNNEL_WRAP_EN
    lx = '{10'd516, 10'd124, 10'd132, 10'd124};
`else
    lx = '{10'd116, 10'd124, 10'd132, 10'd124};
`endif
    ly = '{10'd230, 10'd222, 10'd230, 10'd238};
    wall_px = lx[0]; wall_py = 10'd230;
    tick_sweep(20'h00002, 1'b1, lx, ly, t);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
